variable_printer: RTL and testbench
===================================

// Module: variable_printer
// PURPOSE
//  Read-side partner of the variable creator. Receives a null-terminated ASCII variable name on InsPart.
//  Walks the variable table in data memory through the shared req/grt memory port and fetches the 32-bit value.
//  Streams that value out as decimal ASCII on a byte handshake, terminated by 8'h00, for the console/print path.
// PARAMETERS
//  TABLE_BASE  32'h8000  byte address of first table entry
//  NAME_MAX    8         max name length in bytes, excluding terminator
//  TABLE_MAX   32'h0400  bytes scanned before giving up (runaway guard)
// PORTS
//  Clk        in   1   system clock, all state on rising edge
//  Rst        in   1   synchronous, active-high reset
//  Start      in   1   1-cycle pulse; name bytes follow on the next cycles
//  InsPart    in   8   name byte, one per cycle after Start, 8'h00 ends the name
//  MemReadBus in   32  read data; byte reads use [7:0]; valid the cycle after the address/RDMB cycle
//  grt        in   1   memory-port grant from the arbiter
//  MemAddrBus out  32  byte address
//  RDMB       out  2   read mode: 0 none, 1 byte, 2 half, 3 word
//  req        out  1   memory-port request
//  CharOut    out  8   output ASCII byte
//  CharValid  out  1   CharOut valid; held until CharAck
//  CharAck    in   1   consumer accepts CharOut this cycle
//  HalfReady  out  1   1-cycle pulse when the name terminator is captured
//  Ready      out  1   1-cycle pulse when the operation ends (found or not)
//  NotFound   out  1   sticky error: name missing, overflow, or scan limit; cleared by Start
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, name buffer cleared.
//  Table entry layout: [type byte][name bytes][8'h00][value, 4 bytes little-endian].
//   type 8'h00 marks end of table. type 1 is signed int. Type 2 and 3 values are unsigned.
//  FSM states:
//   IDLE: on Start, clear NotFound and go to NAME.
//   NAME: store InsPart each cycle. On 8'h00, pulse HalfReady and go to REQ.
//    A name byte at index NAME_MAX that is not 8'h00: NotFound=1, Ready pulse, go to IDLE.
//   REQ: req=1. Hold req from here to the end of VAL. On grt, go to RD_TYPE with ptr=TABLE_BASE.
//   RD_TYPE: byte read at ptr.
//    type 0, or ptr-TABLE_BASE >= TABLE_MAX: NotFound=1, drop req, Ready, go to IDLE.
//    Otherwise latch the type, ptr+1, go to CMP with index 0.
//   CMP: byte read.
//    Match with the terminator at the same index: ptr+1, go to VAL.
//    Match, not terminator: ptr+1 and index+1.
//    Mismatch: go to SKIP.
//   SKIP: read bytes until 8'h00, then ptr += 5 (past the terminator and value), go to RD_TYPE.
//   VAL: word read (RDMB=3) at ptr, latch value, drop req, go to CONV.
//   CONV/EMIT:
//    Type 1 with bit31 set: emit '-' (8'h2D) first, then magnitude = 2's complement.
//    Digits by repeated subtraction of 10^9 down to 10^0, leading zeros suppressed, at least one '0'.
//    32'h80000000 signed prints "-2147483648".
//    Each char is presented with CharValid=1 and stable until the CharAck cycle. The next char comes no earlier than the next cycle.
//    After the last digit, emit 8'h00, then pulse Ready and go to IDLE.
//  Memory port handshake:
//   Every read is an address cycle (RDMB != 0) then a data cycle (RDMB = 0).
//   RDMB and MemAddrBus are 0 whenever grt=0. If grt drops mid-walk, stall in place and resume on re-grant.
//  Start outside IDLE is ignored. Rst mid-operation returns to IDLE with req=0 and CharValid=0 the next cycle.
//  CharAck with CharValid=0 is ignored. Ready and CharValid are never 1 in the same cycle.
// STRUCTURE
//  Shared package/header: RDMB encodings, type codes, the FSM state encoding, and the ASCII constants '0' and '-'.
//  Sub-module num2str_serial: 32-bit value plus signed flag in, one char per handshake out.
//   Holds its own power-of-ten counter and subtractor. The top level owns the FSM, name buffer and pointer.
// TESTING
//  Bench pairs the block with the data memory model and keeps grt=1.
//  Table has "69" -> 69 at 8'h8000 and "abc" -> -5 after it. Reads go through the memory's client port.
//  T1: name "abc", CharAck every cycle -> chars 2D,35,00 then Ready. NotFound=0. HalfReady exactly 1 cycle after name 00.
//  T2: name "69", CharAck held low 3 cycles per char -> 36,39,00. Each CharOut stable while CharValid && !CharAck.
//  T3: name "zz" -> no chars, NotFound=1, Ready after hitting the type-0 terminator. req low afterward.
//  T4: value 0 prints 30,00. Value 32'h80000000 (type 1) prints "-2147483648",00. 32'hFFFFFFFF (type 2) prints "4294967295",00.
//  T5: name of 9 bytes -> NotFound=1, Ready, no memory request issued.
//  T6: grt toggled every other cycle during the walk -> same output as T1, RDMB=0 whenever grt=0.
//   Rst asserted mid-EMIT -> CharValid=0 next cycle, and a new Start works.

Source files
------------

// File: rtl/variable_printer_pkg.sv
// Shared encodings for the variable printer: memory read modes, table type codes,
// FSM state encodings, ASCII constants and the power-of-ten lookup.
package variable_printer_pkg;

    localparam logic [1:0] RDMB_NONE = 2'd0;
    localparam logic [1:0] RDMB_BYTE = 2'd1;
    localparam logic [1:0] RDMB_HALF = 2'd2;
    localparam logic [1:0] RDMB_WORD = 2'd3;

    localparam logic [7:0] TYPE_END   = 8'h00;
    localparam logic [7:0] TYPE_INT   = 8'h01;
    localparam logic [7:0] TYPE_UINT  = 8'h02;
    localparam logic [7:0] TYPE_UINT3 = 8'h03;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_NAME    = 3'd1,
        ST_REQ     = 3'd2,
        ST_RD_TYPE = 3'd3,
        ST_CMP     = 3'd4,
        ST_SKIP    = 3'd5,
        ST_VAL     = 3'd6,
        ST_CONV    = 3'd7
    } vp_state_e;

    typedef enum logic [1:0] {
        N2S_IDLE  = 2'd0,
        N2S_SIGN  = 2'd1,
        N2S_DIGIT = 2'd2,
        N2S_TERM  = 2'd3
    } n2s_state_e;

    function automatic logic [31:0] pow10(input logic [3:0] idx);
        case (idx)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/variable_printer_num2str_serial.sv
// Serial 32-bit to decimal ASCII converter: optional '-', digits by repeated
// subtraction of powers of ten, then a NUL terminator, one char per handshake.
module variable_printer_num2str_serial
    import variable_printer_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic [31:0] value_i,
    input  logic        signed_i,
    input  logic        ack_i,
    output logic [7:0]  char_o,
    output logic        valid_o,
    output logic        done_o
);

    n2s_state_e  state_q, state_d;
    logic [31:0] mag_q, mag_d;
    logic [3:0]  pow_idx_q, pow_idx_d;
    logic [3:0]  digit_q, digit_d;
    logic        started_q, started_d;
    logic [7:0]  char_q, char_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic [31:0] pow_s;

    assign pow_s = pow10(pow_idx_q);

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= N2S_IDLE;
            mag_q     <= 32'd0;
            pow_idx_q <= 4'd0;
            digit_q   <= 4'd0;
            started_q <= 1'b0;
            char_q    <= 8'h00;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            pow_idx_q <= pow_idx_d;
            digit_q   <= digit_d;
            started_q <= started_d;
            char_q    <= char_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    // Next-state: a digit is presented once the current power no longer fits
    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        pow_idx_d = pow_idx_q;
        digit_d   = digit_q;
        started_d = started_q;
        char_d    = char_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        case (state_q)
            N2S_IDLE: begin
                if (load_i) begin
                    pow_idx_d = 4'd9;
                    digit_d   = 4'd0;
                    started_d = 1'b0;
                    if (signed_i && value_i[31]) begin
                        mag_d   = ~value_i + 32'd1;
                        char_d  = ASCII_MINUS;
                        valid_d = 1'b1;
                        state_d = N2S_SIGN;
                    end else begin
                        mag_d   = value_i;
                        state_d = N2S_DIGIT;
                    end
                end else begin
                    valid_d = 1'b0;
                end
            end
            N2S_SIGN: begin
                if (ack_i) begin
                    valid_d = 1'b0;
                    state_d = N2S_DIGIT;
                end else begin
                    valid_d = 1'b1;
                end
            end
            N2S_DIGIT: begin
                if (valid_q) begin
                    if (ack_i) begin
                        valid_d = 1'b0;
                        digit_d = 4'd0;
                        if (pow_idx_q == 4'd0) begin
                            state_d = N2S_TERM;
                        end else begin
                            pow_idx_d = pow_idx_q - 4'd1;
                        end
                    end else begin
                        valid_d = 1'b1;
                    end
                end else if (mag_q >= pow_s) begin
                    mag_d   = mag_q - pow_s;
                    digit_d = digit_q + 4'd1;
                end else if ((digit_q != 4'd0) || started_q || (pow_idx_q == 4'd0)) begin
                    char_d    = ASCII_ZERO + {4'd0, digit_q};
                    valid_d   = 1'b1;
                    started_d = 1'b1;
                end else begin
                    pow_idx_d = pow_idx_q - 4'd1;
                end
            end
            N2S_TERM: begin
                if (!valid_q) begin
                    char_d  = ASCII_NUL;
                    valid_d = 1'b1;
                end else if (ack_i) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = N2S_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = N2S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // Outputs come straight from registers
    always_comb begin
        char_o  = char_q;
        valid_o = valid_q;
        done_o  = done_q;
    end

endmodule

// File: rtl/variable_printer.sv
// Looks up a named variable in the data-memory table over the shared req/grt
// port and streams its value as NUL-terminated decimal ASCII.
module variable_printer
    import variable_printer_pkg::*;
#(
    parameter logic [31:0] TABLE_BASE = 32'h8000,
    parameter int          NAME_MAX   = 8,
    parameter logic [31:0] TABLE_MAX  = 32'h0400
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [7:0]  InsPart,
    input  logic [31:0] MemReadBus,
    input  logic        grt,
    output logic [31:0] MemAddrBus,
    output logic [1:0]  RDMB,
    output logic        req,
    output logic [7:0]  CharOut,
    output logic        CharValid,
    input  logic        CharAck,
    output logic        HalfReady,
    output logic        Ready,
    output logic        NotFound
);

    localparam int                IDX_W     = $clog2(NAME_MAX + 1);
    localparam logic [IDX_W-1:0]  NAME_LAST = IDX_W'(NAME_MAX);

    vp_state_e        state_q, state_d;
    logic [7:0]       name_q [0:NAME_MAX];
    logic [7:0]       name_d [0:NAME_MAX];
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      ptr_q, ptr_d;
    logic [7:0]       type_q, type_d;
    logic             phase_q, phase_d;
    logic             req_q, req_d;
    logic             half_q, half_d;
    logic             ready_q, ready_d;
    logic             nf_q, nf_d;
    logic             limit_s;
    logic             load_s;
    logic             n2s_done_s;
    logic [7:0]       rd_byte_s;
    logic [1:0]       rdmb_s;
    logic [31:0]      addr_s;

    assign limit_s   = (ptr_q - TABLE_BASE) >= TABLE_MAX;
    assign rd_byte_s = MemReadBus[7:0];
    assign load_s    = (state_q == ST_VAL) && phase_q && grt;

    variable_printer_num2str_serial u_n2s (
        .clk_i    (Clk),
        .rst_i    (Rst),
        .load_i   (load_s),
        .value_i  (MemReadBus),
        .signed_i (type_q == TYPE_INT),
        .ack_i    (CharAck),
        .char_o   (CharOut),
        .valid_o  (CharValid),
        .done_o   (n2s_done_s)
    );

    // State, name buffer, pointer and registered status outputs
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= ST_IDLE;
            for (int i = 0; i <= NAME_MAX; i++) begin
                name_q[i] <= 8'h00;
            end
            idx_q   <= '0;
            ptr_q   <= 32'd0;
            type_q  <= 8'h00;
            phase_q <= 1'b0;
            req_q   <= 1'b0;
            half_q  <= 1'b0;
            ready_q <= 1'b0;
            nf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            name_q  <= name_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            type_q  <= type_d;
            phase_q <= phase_d;
            req_q   <= req_d;
            half_q  <= half_d;
            ready_q <= ready_d;
            nf_q    <= nf_d;
        end
    end

    // Next-state: each table read is an address phase then a data phase; no grant means stall
    always_comb begin
        state_d = state_q;
        name_d  = name_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        type_d  = type_q;
        phase_d = phase_q;
        half_d  = 1'b0;
        ready_d = 1'b0;
        nf_d    = nf_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    nf_d    = 1'b0;
                    idx_d   = '0;
                    state_d = ST_NAME;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NAME: begin
                name_d[idx_q] = InsPart;
                if (InsPart == ASCII_NUL) begin
                    half_d  = 1'b1;
                    state_d = ST_REQ;
                end else if (idx_q == NAME_LAST) begin
                    nf_d    = 1'b1;
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_REQ: begin
                if (grt) begin
                    ptr_d   = TABLE_BASE;
                    phase_d = 1'b0;
                    state_d = ST_RD_TYPE;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_RD_TYPE, ST_SKIP: begin
                if (!grt) begin
                    state_d = state_q;
                end else if (!phase_q) begin
                    if (limit_s) begin
                        nf_d    = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        phase_d = 1'b1;
                    end
                end else begin
                    phase_d = 1'b0;
                    if (state_q == ST_SKIP) begin
                        if (rd_byte_s == ASCII_NUL) begin
                            ptr_d   = ptr_q + 32'd5;
                            state_d = ST_RD_TYPE;
                        end else begin
                            ptr_d = ptr_q + 32'd1;
                        end
                    end else if (rd_byte_s == TYPE_END) begin
                        nf_d    = 1'b1;
                        ready_d = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        type_d  = rd_byte_s;
                        ptr_d   = ptr_q + 32'd1;
                        idx_d   = '0;
                        state_d = ST_CMP;
                    end
                end
            end
            ST_CMP: begin
                if (!grt) begin
                    state_d = ST_CMP;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    // Mismatch leaves ptr on the offending byte so SKIP re-reads it
                    if (rd_byte_s == name_q[idx_q]) begin
                        ptr_d = ptr_q + 32'd1;
                        if (rd_byte_s == ASCII_NUL) begin
                            state_d = ST_VAL;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_SKIP;
                    end
                end
            end
            ST_VAL: begin
                if (!grt) begin
                    state_d = ST_VAL;
                end else if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                if (n2s_done_s) begin
                    ready_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CONV;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        req_d = (state_d == ST_REQ) || (state_d == ST_RD_TYPE) || (state_d == ST_CMP) ||
                (state_d == ST_SKIP) || (state_d == ST_VAL);
    end

    // Memory port drive: address phase only, forced to zero without grant
    always_comb begin
        rdmb_s = RDMB_NONE;
        addr_s = 32'd0;
        if (grt && !phase_q) begin
            case (state_q)
                ST_RD_TYPE, ST_SKIP: begin
                    if (!limit_s) begin
                        rdmb_s = RDMB_BYTE;
                        addr_s = ptr_q;
                    end else begin
                        rdmb_s = RDMB_NONE;
                        addr_s = 32'd0;
                    end
                end
                ST_CMP: begin
                    rdmb_s = RDMB_BYTE;
                    addr_s = ptr_q;
                end
                ST_VAL: begin
                    rdmb_s = RDMB_WORD;
                    addr_s = ptr_q;
                end
                default: begin
                    rdmb_s = RDMB_NONE;
                    addr_s = 32'd0;
                end
            endcase
        end else begin
            rdmb_s = RDMB_NONE;
            addr_s = 32'd0;
        end
    end

    assign RDMB       = rdmb_s;
    assign MemAddrBus = addr_s;
    assign req        = req_q;
    assign HalfReady  = half_q;
    assign Ready      = ready_q;
    assign NotFound   = nf_q;

endmodule

// File: tb/tb_variable_printer.sv
// Self-checking bench for variable_printer: byte-array data memory, a string-level
// lookup/format model, and a per-cycle compare process on the char stream and bus.
module tb_variable_printer;

    logic        Clk = 1'b0;
    logic        Rst, Start, grt, CharAck;
    logic [7:0]  InsPart;
    logic [31:0] MemReadBus, MemAddrBus;
    logic [1:0]  RDMB;
    logic        req, CharValid, HalfReady, Ready, NotFound;
    logic [7:0]  CharOut;

    always #5 Clk = ~Clk;

    variable_printer dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .InsPart(InsPart),
        .MemReadBus(MemReadBus), .grt(grt), .MemAddrBus(MemAddrBus), .RDMB(RDMB),
        .req(req), .CharOut(CharOut), .CharValid(CharValid), .CharAck(CharAck),
        .HalfReady(HalfReady), .Ready(Ready), .NotFound(NotFound)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  mem [0:255];
    logic [31:0] mem_rd = 32'd0;
    assign MemReadBus = mem_rd;

    string        ent_name [$];
    logic [31:0]  ent_val  [$];
    logic [7:0]   ent_type [$];
    int           wptr = 0;

    byte unsigned exp_q [$];
    string        got_s;
    int           ready_cnt, half_cnt;
    bit           req_seen;
    bit           mon_en = 1'b0;
    logic         prev_valid = 1'b0, prev_ack = 1'b0;
    logic [7:0]   prev_char = 8'h00;

    function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] m);
        logic [7:0] o;
        o = 8'(a - 32'h8000);
        case (m)
            2'd1:    return {24'd0, mem[o]};
            2'd2:    return {16'd0, mem[o + 8'd1], mem[o]};
            2'd3:    return {mem[o + 8'd3], mem[o + 8'd2], mem[o + 8'd1], mem[o]};
            default: return 32'd0;
        endcase
    endfunction

    // Data memory: registered read, data valid the cycle after the address cycle
    always @(posedge Clk) begin
        if (RDMB != 2'd0) mem_rd <= mem_read(MemAddrBus, RDMB);
    end

    function automatic string fmt_val(input logic [31:0] v, input logic [7:0] t);
        if (t == 8'd1) return $sformatf("%0d", $signed(v));
        return $sformatf("%0d", v);
    endfunction

    function automatic string model_lookup(input string nm, output bit found);
        string r;
        found = 1'b0;
        r = "";
        if (nm.len() <= 8) begin
            foreach (ent_name[i]) begin
                if (!found && ent_name[i] == nm) begin
                    found = 1'b1;
                    r = fmt_val(ent_val[i], ent_type[i]);
                end
            end
        end
        return r;
    endfunction

    task automatic add_entry(input logic [7:0] t, input string nm, input logic [31:0] v);
        mem[8'(wptr)] = t; wptr++;
        for (int i = 0; i < nm.len(); i++) begin mem[8'(wptr)] = nm[i]; wptr++; end
        mem[8'(wptr)] = 8'h00; wptr++;
        for (int k = 0; k < 4; k++) begin mem[8'(wptr)] = v[8*k +: 8]; wptr++; end
        ent_name.push_back(nm); ent_val.push_back(v); ent_type.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
        end
    endtask

    task automatic chk_str(input string nm, input string act, input string exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=\"%s\" required=\"%s\"", nm, act, exp_v);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #2;
    endtask

    // Compare process: bus idle without grant, char stability and stream contents
    initial begin
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (!grt) begin
                    chk("bus_idle_no_grt", {RDMB, MemAddrBus[29:0]}, 32'd0);
                    chk("addr_hi_no_grt", {30'd0, MemAddrBus[31:30]}, 32'd0);
                end
                if (Ready) chk("ready_with_valid", 32'(CharValid), 32'd0);
                if (prev_valid && !prev_ack) begin
                    chk("char_valid_held", 32'(CharValid), 32'd1);
                    chk("char_stable", 32'(CharOut), 32'(prev_char));
                end
                if (CharValid && CharAck) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL char_extra actual=%0h required=none", CharOut);
                    end else begin
                        chk("char_stream", 32'(CharOut), 32'(exp_q.pop_front()));
                    end
                    if (CharOut != 8'h00) got_s = {got_s, $sformatf("%c", CharOut)};
                end
                if (Ready) ready_cnt++;
                if (HalfReady) half_cnt++;
                if (req) req_seen = 1'b1;
                prev_valid = CharValid;
                prev_ack   = CharAck;
                prev_char  = CharOut;
            end
        end
    end

    task automatic send_name(input string nm);
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < nm.len(); i++) begin
            InsPart = nm[i];
            step();
        end
        InsPart = 8'h00;
        step();
    endtask

    task automatic run_op(input string tag, input string nm, input int hold, input bit toggle);
        bit    found;
        bit    long_nm;
        string s;
        int    wcnt;
        int    cyc;
        s = model_lookup(nm, found);
        exp_q.delete();
        if (found) begin
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            exp_q.push_back(8'h00);
        end
        long_nm   = nm.len() > 8;
        ready_cnt = 0;
        half_cnt  = 0;
        req_seen  = 1'b0;
        got_s     = "";
        send_name(nm);
        chk({tag, "_halfready_next"}, 32'(HalfReady), 32'(!long_nm));
        wcnt = 0;
        cyc  = 0;
        while (ready_cnt == 0 && cyc < 4000) begin
            grt = toggle ? ~grt : 1'b1;
            if (hold < 0) begin
                CharAck = 1'b1;
            end else if (CharValid) begin
                if (wcnt >= hold) begin CharAck = 1'b1; wcnt = 0; end
                else begin CharAck = 1'b0; wcnt++; end
            end else begin
                CharAck = 1'b0;
            end
            step();
            cyc++;
        end
        grt = 1'b1;
        CharAck = 1'b0;
        repeat (3) step();
        chk({tag, "_ready_count"}, 32'(ready_cnt), 32'd1);
        chk({tag, "_notfound"}, 32'(NotFound), 32'(!found));
        chk({tag, "_chars_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_halfready_count"}, 32'(half_cnt), 32'(!long_nm));
        chk({tag, "_req_after"}, 32'(req), 32'd0);
        if (long_nm) chk({tag, "_no_req"}, 32'(req_seen), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        Rst = 1'b1; Start = 1'b0; InsPart = 8'h00; grt = 1'b1; CharAck = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        add_entry(8'd2, "69",   32'd69);
        add_entry(8'd1, "abc",  32'hFFFFFFFB);
        add_entry(8'd1, "neg",  32'h80000000);
        add_entry(8'd2, "umax", 32'hFFFFFFFF);
        add_entry(8'd3, "z",    32'd0);

        repeat (3) step();
        chk("rst_charvalid", 32'(CharValid), 32'd0);
        chk("rst_outputs", {20'd0, CharOut, req, Ready, HalfReady, NotFound}, 32'd0);
        chk("rst_bus", {RDMB, MemAddrBus[29:0]}, 32'd0);
        Rst = 1'b0;
        step();
        mon_en = 1'b1;

        chk_str("pin_fmt_neg5", fmt_val(32'hFFFFFFFB, 8'd1), "-5");
        chk_str("pin_fmt_min", fmt_val(32'h80000000, 8'd1), "-2147483648");
        chk_str("pin_fmt_umax", fmt_val(32'hFFFFFFFF, 8'd2), "4294967295");
        chk_str("pin_fmt_zero", fmt_val(32'd0, 8'd3), "0");

        run_op("t1", "abc", -1, 1'b0);
        chk_str("t1_text", got_s, "-5");
        run_op("t2", "69", 3, 1'b0);
        chk_str("t2_text", got_s, "69");
        run_op("t3", "zz", -1, 1'b0);
        chk_str("t3_text", got_s, "");
        run_op("t3b", "ab", 0, 1'b0);
        run_op("t4z", "z", 0, 1'b0);
        chk_str("t4_zero_text", got_s, "0");
        run_op("t4n", "neg", -1, 1'b0);
        chk_str("t4_min_text", got_s, "-2147483648");
        run_op("t4u", "umax", 1, 1'b0);
        chk_str("t4_umax_text", got_s, "4294967295");
        run_op("t5", "abcdefghi", -1, 1'b0);
        run_op("t6", "abc", -1, 1'b1);
        chk_str("t6_text", got_s, "-5");

        exp_q.delete();
        CharAck = 1'b0;
        send_name("umax");
        cyc = 0;
        while (!CharValid && cyc < 2000) begin step(); cyc++; end
        chk("rst_mid_emit_valid_seen", 32'(CharValid), 32'd1);
        mon_en = 1'b0;
        Rst = 1'b1;
        step();
        chk("rst_mid_emit_charvalid", 32'(CharValid), 32'd0);
        chk("rst_mid_emit_req", 32'(req), 32'd0);
        Rst = 1'b0;
        step();
        prev_valid = 1'b0;
        prev_ack   = 1'b0;
        mon_en = 1'b1;
        run_op("t7", "abc", -1, 1'b0);
        chk_str("t7_text", got_s, "-5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
